dmem_arbiter: RTL and testbench

Two-master arbiter and power-up clear sequencer sitting in front of the single-port data memory (`data_memory`). It shares the memory's one write/read port between master 0 (core load/store) and master 1 (debug/DMA loader) with round-robin priority, and after reset sweeps every memory word to zero before granting any access.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter_if.sv | 49 ++++
 rtl/dmem_clear_seq.sv | 35 +++
 rtl/dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
// Define DMEM_CLEAR_EN to build in the power-up clear sweep.
package dmem_arb_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        ARB   = 1'b1
    } state_t;

    localparam bit M0 = 1'b0;
    localparam bit M1 = 1'b1;

`ifdef DMEM_CLEAR_EN
    localparam bit     CLEAR_EN  = 1'b1;
    localparam state_t RST_STATE = CLEAR;
`else
    localparam bit     CLEAR_EN  = 1'b0;
    localparam state_t RST_STATE = ARB;
`endif

    // Round-robin hand-off: after a grant the other master is favoured.
    function automatic bit other_master(input bit m);
        return ~m;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the masters+memory side.
interface dmem_arbiter_if #(
    parameter int WIDTH = 32,
    parameter int AW    = 8
);
    logic             m0_req;
    logic             m0_we;
    logic [AW-1:0]    m0_addr;
    logic [WIDTH-1:0] m0_wdata;
    logic             m0_gnt;
    logic [WIDTH-1:0] m0_rdata;
    logic             m0_rvalid;

    logic             m1_req;
    logic             m1_we;
    logic [AW-1:0]    m1_addr;
    logic [WIDTH-1:0] m1_wdata;
    logic             m1_gnt;
    logic [WIDTH-1:0] m1_rdata;
    logic             m1_rvalid;

    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             busy;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rdata, m0_rvalid,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_gnt, m1_rdata, m1_rvalid,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rdata, m0_rvalid,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_gnt, m1_rdata, m1_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy
    );

endinterface

// File: rtl/dmem_clear_seq.sv
// Address counter for the power-up clear sweep; done flags the last word.
// Only instantiated when DMEM_CLEAR_EN is defined.
module dmem_clear_seq #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic [AW-1:0] clr_addr,
    output logic          done
);

    logic [AW-1:0] clr_cnt_reg;
    logic [AW-1:0] clr_cnt_next;

    assign done     = (clr_cnt_reg == AW'(DEPTH - 1));
    assign clr_addr = clr_cnt_reg;

    always_comb begin
        clr_cnt_next = clr_cnt_reg;
        if (en) begin
            clr_cnt_next = done ? '0 : clr_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_reg <= '0;
        end else begin
            clr_cnt_reg <= clr_cnt_next;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one memory port between two masters, with an
// optional power-up zero sweep selected by the DMEM_CLEAR_EN macro.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);

    if (DEPTH > (1 << AW)) begin : g_depth_chk
        $error("DEPTH does not fit in AW address bits");
    end

    state_t           state_reg;
    state_t           state_next;
    logic             rr_reg;
    logic             rr_next;
    logic             win_idx;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             busy;

    logic             req   [2];
    logic             we    [2];
    logic [AW-1:0]    addr  [2];
    logic [WIDTH-1:0] wdata [2];
    logic             gnt   [2];

    assign req[M0]   = bus.m0_req;
    assign we[M0]    = bus.m0_we;
    assign addr[M0]  = bus.m0_addr;
    assign wdata[M0] = bus.m0_wdata;
    assign req[M1]   = bus.m1_req;
    assign we[M1]    = bus.m1_we;
    assign addr[M1]  = bus.m1_addr;
    assign wdata[M1] = bus.m1_wdata;

`ifdef DMEM_CLEAR_EN
    logic          clr_en;
    logic [AW-1:0] clr_addr;
    logic          clr_done;

    dmem_clear_seq #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear_seq (
        .clk      (clk),
        .rst      (rst),
        .en       (clr_en),
        .clr_addr (clr_addr),
        .done     (clr_done)
    );
`endif

    always_comb begin
        state_next = state_reg;
        rr_next    = rr_reg;
        win_idx    = M0;
        gnt[M0]    = 1'b0;
        gnt[M1]    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        busy       = 1'b0;
`ifdef DMEM_CLEAR_EN
        clr_en     = 1'b0;
`endif
        // Reset gates every output combinationally, not just the state.
        if (rst) begin
            busy = CLEAR_EN;
        end else begin
            case (state_reg)
                CLEAR: begin
`ifdef DMEM_CLEAR_EN
                    clr_en   = 1'b1;
                    busy     = 1'b1;
                    mem_we   = 1'b1;
                    mem_addr = WIDTH'(clr_addr);
                    if (clr_done) begin
                        state_next = ARB;
                    end
`else
                    state_next = ARB;
`endif
                end
                ARB: begin
                    if (req[M0] && (!req[M1] || rr_reg == M0)) begin
                        gnt[M0] = 1'b1;
                        win_idx = M0;
                    end else if (req[M1]) begin
                        gnt[M1] = 1'b1;
                        win_idx = M1;
                    end
                    if (gnt[M0] || gnt[M1]) begin
                        rr_next   = other_master(win_idx);
                        mem_we    = we[win_idx];
                        mem_addr  = WIDTH'(addr[win_idx]);
                        mem_wdata = wdata[win_idx];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RST_STATE;
            rr_reg    <= M0;
        end else begin
            state_reg <= state_next;
            rr_reg    <= rr_next;
        end
    end

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_rd
        logic [WIDTH-1:0] rdata_reg;
        logic             rvalid_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                rdata_reg  <= '0;
                rvalid_reg <= 1'b0;
            end else begin
                rvalid_reg <= gnt[gi] && !we[gi];
                if (gnt[gi] && !we[gi]) begin
                    rdata_reg <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.m0_gnt    = gnt[M0];
    assign bus.m1_gnt    = gnt[M1];
    assign bus.m0_rdata  = g_rd[0].rdata_reg;
    assign bus.m0_rvalid = g_rd[0].rvalid_reg;
    assign bus.m1_rdata  = g_rd[1].rdata_reg;
    assign bus.m1_rvalid = g_rd[1].rvalid_reg;
    assign bus.mem_we    = mem_we;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, clear-sweep
// and reset sequences, then random traffic against a behavioural model.
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

    dmem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Physical memory behind the port: combinational read, write at the edge.
    logic [WIDTH-1:0] phys    [DEPTH];
    logic [WIDTH-1:0] ref_mem [DEPTH];

    assign bus.mem_rdata = phys[bus.mem_addr[AW-1:0]];

    always @(posedge clk) begin
        if (bus.mem_we === 1'b1) phys[bus.mem_addr[AW-1:0]] <= bus.mem_wdata;
    end

    typedef struct {
        bit          r0; bit w0; int a0; logic [31:0] d0;
        bit          r1; bit w1; int a1; logic [31:0] d1;
        bit          g0; bit g1; bit v0; bit v1;
        logic [31:0] q0; logic [31:0] q1;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit r0, input bit w0, input int a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input int a1, input logic [31:0] d1);
        bus.m0_req = r0; bus.m0_we = w0; bus.m0_addr = AW'(a0); bus.m0_wdata = d0;
        bus.m1_req = r1; bus.m1_we = w1; bus.m1_addr = AW'(a1); bus.m1_wdata = d1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk($sformatf("rst%0d_busy", i), 32'(bus.busy), 32'(CLEAR_EN));
            chk($sformatf("rst%0d_gnt0", i), 32'(bus.m0_gnt), 32'd0);
            chk($sformatf("rst%0d_gnt1", i), 32'(bus.m1_gnt), 32'd0);
            chk($sformatf("rst%0d_mem_we", i), 32'(bus.mem_we), 32'd0);
            chk($sformatf("rst%0d_rvalid0", i), 32'(bus.m0_rvalid), 32'd0);
            chk($sformatf("rst%0d_rdata0", i), bus.m0_rdata, 32'd0);
        end
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic check_sweep(input bit hold_m1);
        for (int c = 0; c <= DEPTH; c++) begin
            if (hold_m1 && c == 10) drive(0, 0, 0, 0, 1, 1, 7, 32'h7777_7777);
            @(negedge clk);
            if (c < DEPTH) begin
                chk($sformatf("sweep%0d_busy", c), 32'(bus.busy), 32'd1);
                chk($sformatf("sweep%0d_we", c), 32'(bus.mem_we), 32'd1);
                chk($sformatf("sweep%0d_addr", c), bus.mem_addr, 32'(c));
                chk($sformatf("sweep%0d_wdata", c), bus.mem_wdata, 32'd0);
                if (hold_m1) chk($sformatf("sweep%0d_m1_gnt", c), 32'(bus.m1_gnt), 32'd0);
            end else begin
                chk("sweep_end_busy", 32'(bus.busy), 32'd0);
                if (hold_m1) chk("sweep_end_m1_gnt", 32'(bus.m1_gnt), 32'd1);
                else         chk("sweep_end_idle_we", 32'(bus.mem_we), 32'd0);
            end
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        $display("sweep done hold_m1=%0d", hold_m1);
    endtask

    task automatic fresh_start();
        do_reset();
`ifdef DMEM_CLEAR_EN
        repeat (DEPTH) begin
            @(posedge clk); #1;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`endif
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit          pr [2];
        bit          pw [2];
        int          pa [2];
        logic [31:0] pd [2];
        bit          erv [2];
        logic [31:0] erd [2];
        int          last_win;
        int          win;

        for (int i = 0; i < DEPTH; i++) begin
`ifdef DMEM_CLEAR_EN
            phys[i] = 32'hA5A5_0000 | 32'(i);
`else
            phys[i] = '0;
`endif
            ref_mem[i] = '0;
        end
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

`ifdef DMEM_CLEAR_EN
        do_reset();
        check_sweep(1'b1);
        // Reset pulse in the middle of a sweep restarts it from address 0.
        do_reset();
        repeat (100) begin
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("midclear_addr100", bus.mem_addr, 32'd100);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_sweep(1'b0);
`else
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        do_reset();
        @(negedge clk);
        chk("cycle0_gnt0", 32'(bus.m0_gnt), 32'd1);
        chk("cycle0_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("cycle1_rvalid0", 32'(bus.m0_rvalid), 32'd1);
        chk("cycle1_rdata0", bus.m0_rdata, 32'd0);
        @(posedge clk); #1;
`endif

        // Directed table: starts with master 0 favoured and memory cleared.
        vt[0]  = '{1,1,5,32'hDEADBEEF, 0,0,0,0, 1,0,0,0, 32'h0,        32'h0};
        vt[1]  = '{1,0,5,0,            0,0,0,0, 1,0,0,0, 32'h0,        32'h0};
        vt[2]  = '{1,0,6,0,            0,0,0,0, 1,0,1,0, 32'hDEADBEEF, 32'h0};
        vt[3]  = '{0,0,0,0, 1,1,1,32'h1111_1111, 0,1,1,0, 32'h0,        32'h0};
        vt[4]  = '{0,0,0,0, 1,1,2,32'h2222_2222, 0,1,0,0, 32'h0,        32'h0};
        vt[5]  = '{1,0,1,0,            1,0,2,0, 1,0,0,0, 32'h0,        32'h0};
        vt[6]  = '{1,0,1,0,            1,0,2,0, 0,1,1,0, 32'h1111_1111, 32'h0};
        vt[7]  = '{1,0,1,0,            1,0,2,0, 1,0,0,1, 32'h1111_1111, 32'h2222_2222};
        vt[8]  = '{1,0,1,0,            1,0,2,0, 0,1,1,0, 32'h1111_1111, 32'h2222_2222};
        vt[9]  = '{0,0,0,0,            0,0,0,0, 0,0,0,1, 32'h1111_1111, 32'h2222_2222};
        vt[10] = '{0,0,0,0,            0,0,0,0, 0,0,0,0, 32'h1111_1111, 32'h2222_2222};

        fresh_start();
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].r0, vt[i].w0, vt[i].a0, vt[i].d0, vt[i].r1, vt[i].w1, vt[i].a1, vt[i].d1);
            @(negedge clk);
            chk($sformatf("vec%0d_gnt0", i), 32'(bus.m0_gnt), 32'(vt[i].g0));
            chk($sformatf("vec%0d_gnt1", i), 32'(bus.m1_gnt), 32'(vt[i].g1));
            chk($sformatf("vec%0d_rvalid0", i), 32'(bus.m0_rvalid), 32'(vt[i].v0));
            chk($sformatf("vec%0d_rvalid1", i), 32'(bus.m1_rvalid), 32'(vt[i].v1));
            chk($sformatf("vec%0d_rdata0", i), bus.m0_rdata, vt[i].q0);
            chk($sformatf("vec%0d_rdata1", i), bus.m1_rdata, vt[i].q1);
            chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
            @(posedge clk); #1;
            if (vt[i].g0 && vt[i].w0) ref_mem[vt[i].a0] = vt[i].d0;
            if (vt[i].g1 && vt[i].w1) ref_mem[vt[i].a1] = vt[i].d1;
            $display("vec %0d gnt=%0d%0d rvalid=%0d%0d", i, vt[i].g0, vt[i].g1, vt[i].v0, vt[i].v1);
        end

        // Random traffic: model grants the requester that did not win last.
        last_win = 1;
        erv[0] = 0; erv[1] = 0;
        erd[0] = 32'h1111_1111; erd[1] = 32'h2222_2222;
        pr[0] = 0; pr[1] = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pr[m] && $urandom_range(0, 9) < 7) begin
                    pr[m] = 1;
                    pw[m] = 1'($urandom_range(0, 1));
                    pa[m] = int'($urandom_range(0, 15));
                    pd[m] = $urandom;
                end
            end
            drive(pr[0], pw[0], pa[0], pd[0], pr[1], pw[1], pa[1], pd[1]);
            if (pr[0] && pr[1]) win = (last_win == 0) ? 1 : 0;
            else if (pr[0])     win = 0;
            else if (pr[1])     win = 1;
            else                win = -1;
            @(negedge clk);
            chk($sformatf("rnd%0d_gnt0", cyc), 32'(bus.m0_gnt), 32'(win == 0));
            chk($sformatf("rnd%0d_gnt1", cyc), 32'(bus.m1_gnt), 32'(win == 1));
            chk($sformatf("rnd%0d_busy", cyc), 32'(bus.busy), 32'd0);
            chk($sformatf("rnd%0d_rvalid0", cyc), 32'(bus.m0_rvalid), 32'(erv[0]));
            chk($sformatf("rnd%0d_rvalid1", cyc), 32'(bus.m1_rvalid), 32'(erv[1]));
            chk($sformatf("rnd%0d_rdata0", cyc), bus.m0_rdata, erd[0]);
            chk($sformatf("rnd%0d_rdata1", cyc), bus.m1_rdata, erd[1]);
            if (win >= 0) begin
                chk($sformatf("rnd%0d_mem_we", cyc), 32'(bus.mem_we), 32'(pw[win]));
                chk($sformatf("rnd%0d_mem_addr", cyc), bus.mem_addr, 32'(pa[win]));
                chk($sformatf("rnd%0d_mem_wdata", cyc), bus.mem_wdata, pd[win]);
            end else begin
                chk($sformatf("rnd%0d_idle_we", cyc), 32'(bus.mem_we), 32'd0);
                chk($sformatf("rnd%0d_idle_addr", cyc), bus.mem_addr, 32'd0);
            end
            @(posedge clk); #1;
            erv[0] = 0; erv[1] = 0;
            if (win >= 0) begin
                if (pw[win]) ref_mem[pa[win]] = pd[win];
                else begin
                    erv[win] = 1;
                    erd[win] = ref_mem[pa[win]];
                end
                last_win = win;
                pr[win]  = 0;
            end
            $display("rnd %0d win=%0d", cyc, win);
        end

        // Reset while a read result is on the bus drops that result.
        drive(1, 0, 5, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midread_gnt0", 32'(bus.m0_gnt), 32'd1);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("midread_rvalid0_pre", 32'(bus.m0_rvalid), 32'd1);
        chk("midread_rdata0_pre", bus.m0_rdata, ref_mem[5]);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midread_rvalid0_post", 32'(bus.m0_rvalid), 32'd0);
        chk("midread_rdata0_post", bus.m0_rdata, 32'd0);
        $display("midread reset done");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
